// File: rtl/count_wrap_pkg.sv
// Shared types and constants for the count wrap-around monitor.
package count_wrap_pkg;

  typedef enum logic {
    UNPRIMED = 1'b0,
    TRACK    = 1'b1
  } fsm_state_t;

  localparam logic DIR_UP = 1'b1;
  localparam logic DIR_DN = 1'b0;

  // Consumer-side view of one event at the default tally width.
  localparam int DEFAULT_TALLY_W = 8;

  typedef struct packed {
    logic                       dir;
    logic [DEFAULT_TALLY_W-1:0] tally;
  } evt_rec_t;

endpackage

// File: rtl/evt_fifo2.sv
// Two-entry in-order valid/ready buffer; head and valid come straight from flops.
module evt_fifo2 #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_push,
  input  logic [W-1:0] i_data,
  output logic         o_overflow,
  output logic         o_valid,
  input  logic         i_ready,
  output logic [W-1:0] o_data
);

  logic [W-1:0] r_head;
  logic [W-1:0] r_tail;
  logic         r_head_vld;
  logic         r_tail_vld;
  logic         w_pop;
  logic         w_full;
  logic         w_push_ok;
  logic         w_land_tail;

  assign w_pop       = r_head_vld & i_ready;
  assign w_full      = r_head_vld & r_tail_vld;
  assign w_push_ok   = i_push & (~w_full | w_pop);
  assign o_overflow  = i_push & w_full & ~w_pop;
  // An accepted entry lands in the tail whenever the head slot stays occupied.
  assign w_land_tail = w_push_ok & (w_pop ? r_tail_vld : r_head_vld);

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_head_vld <= 1'b0;
      r_tail_vld <= 1'b0;
    end else if (w_pop) begin
      r_head_vld <= r_tail_vld | w_push_ok;
      r_tail_vld <= r_tail_vld & w_push_ok;
    end else if (w_push_ok) begin
      if (r_head_vld) r_tail_vld <= 1'b1;
      else            r_head_vld <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_head <= '0;
    end else if (w_pop) begin
      if (r_tail_vld)     r_head <= r_tail;
      else if (w_push_ok) r_head <= i_data;
    end else if (w_push_ok && !r_head_vld) begin
      r_head <= i_data;
    end
  end

  // NOTE: the tail payload has no reset; it is never visible until its valid bit is set.
  always_ff @(posedge clk) begin
    if (w_land_tail) r_tail <= i_data;
  end

  assign o_valid = r_head_vld;
  assign o_data  = r_head;

endmodule

// File: rtl/count_wrap_monitor.sv
// Observes an up/down counter, tallies wrap-arounds and queues one event per wrap.
// Optional step legality checker and jump_err port: define COUNT_WRAP_JUMP_CHK_EN.
module count_wrap_monitor
  import count_wrap_pkg::*;
#(
  parameter int CNT_W   = 4,
  parameter int TALLY_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               en,
  input  logic [CNT_W-1:0]   count,
  input  logic               updown,
  output logic               evt_valid,
  input  logic               evt_ready,
  output logic               evt_dir,
  output logic [TALLY_W-1:0] evt_tally,
  output logic [TALLY_W-1:0] up_wraps,
  output logic [TALLY_W-1:0] dn_wraps,
  output logic               drop
`ifdef COUNT_WRAP_JUMP_CHK_EN
  ,
  output logic               jump_err
`endif
);

  localparam logic [CNT_W-1:0]   CNT_MAX   = '1;
  localparam logic [TALLY_W-1:0] TALLY_MAX = '1;

  typedef struct packed {
    logic               dir;
    logic [TALLY_W-1:0] tally;
  } evt_t;

  localparam int REC_W = $bits(evt_t);

  fsm_state_t         r_state;
  fsm_state_t         w_state_next;
  logic [CNT_W-1:0]   r_prev_cnt;
  logic               r_prev_dir;
  logic [TALLY_W-1:0] r_up_wraps;
  logic [TALLY_W-1:0] r_dn_wraps;
  logic [TALLY_W-1:0] w_up_inc;
  logic [TALLY_W-1:0] w_dn_inc;
  logic               r_drop;
  logic               w_step_ok;
  logic               w_up_wrap;
  logic               w_dn_wrap;
  logic               w_push;
  logic               w_overflow;
  logic               w_fifo_valid;
  logic [REC_W-1:0]   w_fifo_dout;
  evt_t               w_push_rec;
  evt_t               w_head_rec;

`ifdef COUNT_WRAP_JUMP_CHK_EN
  logic [CNT_W-1:0] w_step;
  logic             r_jump_err;

  assign w_step    = count - r_prev_cnt;
  assign w_step_ok = (w_step == '0)
                   | ((r_prev_dir == DIR_UP) && (w_step == CNT_W'(1)))
                   | ((r_prev_dir == DIR_DN) && (w_step == CNT_MAX));

  always_ff @(posedge clk) begin
    if (rst)                                          r_jump_err <= 1'b0;
    else if ((r_state == TRACK) && en && !w_step_ok)  r_jump_err <= 1'b1;
  end

  assign jump_err = r_jump_err;
`else
  assign w_step_ok = 1'b1;
`endif

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    w_state_next = r_state;
    w_up_wrap    = 1'b0;
    w_dn_wrap    = 1'b0;
    case (r_state)
      UNPRIMED: if (en) w_state_next = TRACK;
      TRACK: begin
        if (en) begin
          w_up_wrap = w_step_ok && (r_prev_dir == DIR_UP)
                   && (r_prev_cnt == CNT_MAX) && (count == '0);
          w_dn_wrap = w_step_ok && (r_prev_dir == DIR_DN)
                   && (r_prev_cnt == '0) && (count == CNT_MAX);
        end
      end
      default: w_state_next = UNPRIMED;
    endcase
  end

  assign w_up_inc = (r_up_wraps == TALLY_MAX) ? r_up_wraps : r_up_wraps + TALLY_W'(1);
  assign w_dn_inc = (r_dn_wraps == TALLY_MAX) ? r_dn_wraps : r_dn_wraps + TALLY_W'(1);
  assign w_push   = w_up_wrap | w_dn_wrap;

  always_comb begin
    w_push_rec.dir   = w_up_wrap ? DIR_UP : DIR_DN;
    w_push_rec.tally = w_up_wrap ? w_up_inc : w_dn_inc;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state    <= UNPRIMED;
      r_prev_cnt <= '0;
      r_prev_dir <= DIR_DN;
      r_up_wraps <= '0;
      r_dn_wraps <= '0;
      r_drop     <= 1'b0;
    end else begin
      r_state <= w_state_next;
      if (en) begin
        r_prev_cnt <= count;
        r_prev_dir <= updown;
      end
      if (w_up_wrap)  r_up_wraps <= w_up_inc;
      if (w_dn_wrap)  r_dn_wraps <= w_dn_inc;
      if (w_overflow) r_drop     <= 1'b1;
    end
  end

  evt_fifo2 #(
    .W (REC_W)
  ) u_fifo (
    .clk        (clk),
    .rst        (rst),
    .i_push     (w_push),
    .i_data     (w_push_rec),
    .o_overflow (w_overflow),
    .o_valid    (w_fifo_valid),
    .i_ready    (evt_ready),
    .o_data     (w_fifo_dout)
  );

  assign w_head_rec = w_fifo_dout;
  assign evt_valid  = w_fifo_valid;
  assign evt_dir    = w_head_rec.dir;
  assign evt_tally  = w_head_rec.tally;
  assign up_wraps   = r_up_wraps;
  assign dn_wraps   = r_dn_wraps;
  assign drop       = r_drop;

endmodule

// File: tb/tb_count_wrap_monitor.sv
// Directed bench for count_wrap_monitor: a vector table plus multi-cycle corner sequences.
module tb_count_wrap_monitor;
  import count_wrap_pkg::*;

  logic       clk = 1'b0;
  logic       rst;
  logic       en;
  logic [3:0] count;
  logic       updown;
  logic       evt_ready;

  logic       d_valid, d_dir, d_drop;
  logic [7:0] d_tally, d_up, d_dn;
  logic       s_valid, s_dir, s_drop;
  logic [1:0] s_tally, s_up, s_dn;
`ifdef COUNT_WRAP_JUMP_CHK_EN
  logic       d_jump, s_jump;
`endif

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  count_wrap_monitor #(.CNT_W(4), .TALLY_W(8)) u_dut (
    .clk(clk), .rst(rst), .en(en), .count(count), .updown(updown),
    .evt_valid(d_valid), .evt_ready(evt_ready), .evt_dir(d_dir), .evt_tally(d_tally),
    .up_wraps(d_up), .dn_wraps(d_dn), .drop(d_drop)
`ifdef COUNT_WRAP_JUMP_CHK_EN
    , .jump_err(d_jump)
`endif
  );

  count_wrap_monitor #(.CNT_W(4), .TALLY_W(2)) u_sat (
    .clk(clk), .rst(rst), .en(en), .count(count), .updown(updown),
    .evt_valid(s_valid), .evt_ready(evt_ready), .evt_dir(s_dir), .evt_tally(s_tally),
    .up_wraps(s_up), .dn_wraps(s_dn), .drop(s_drop)
`ifdef COUNT_WRAP_JUMP_CHK_EN
    , .jump_err(s_jump)
`endif
  );

  typedef struct {
    logic       en;
    logic [3:0] cnt;
    logic       ud;
    logic       exp_valid;
    logic       exp_dir;
    logic [7:0] exp_tally;
    logic [7:0] exp_up;
    logic [7:0] exp_dn;
  } vec_t;

  vec_t vq[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic e, input logic [3:0] c, input logic u, input logic v,
                     input logic d, input logic [7:0] t, input logic [7:0] up,
                     input logic [7:0] dn);
    vq.push_back('{e, c, u, v, d, t, up, dn});
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    tick();
    rst = 1'b0;
  endtask

  // Counts 1..15 upward, leaving count at 15.
  task automatic ramp_to15();
    en     = 1'b1;
    updown = 1'b1;
    for (int i = 1; i < 16; i++) begin
      count = 4'(i);
      tick();
    end
  endtask

  task automatic up_wrap_full();
    ramp_to15();
    count = 4'd0;
    tick();
  endtask

  task automatic prime15();
    en     = 1'b1;
    updown = 1'b1;
    count  = 4'd15;
    tick();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    evt_rec_t rec;
    rst       = 1'b1;
    en        = 1'b0;
    count     = 4'd0;
    updown    = 1'b1;
    evt_ready = 1'b1;

    // Ramp 0..15 then wrap, down run 2,1,0,15, hold, then non-wrap boundary cases.
    for (int i = 0; i < 16; i++) add(1'b1, 4'(i), 1'b1, 1'b0, 1'b0, 8'd0, 8'd0, 8'd0);
    add(1'b1, 4'd0,  1'b1, 1'b1, DIR_UP, 8'd1, 8'd1, 8'd0);
    add(1'b1, 4'd1,  1'b1, 1'b0, 1'b0,   8'd0, 8'd1, 8'd0);
    add(1'b1, 4'd2,  1'b0, 1'b0, 1'b0,   8'd0, 8'd1, 8'd0);
    add(1'b1, 4'd1,  1'b0, 1'b0, 1'b0,   8'd0, 8'd1, 8'd0);
    add(1'b1, 4'd0,  1'b0, 1'b0, 1'b0,   8'd0, 8'd1, 8'd0);
    add(1'b1, 4'd15, 1'b0, 1'b1, DIR_DN, 8'd1, 8'd1, 8'd1);
    add(1'b0, 4'd9,  1'b1, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);
    add(1'b1, 4'd14, 1'b1, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);
    add(1'b1, 4'd15, 1'b1, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);
    add(1'b1, 4'd14, 1'b0, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);
    add(1'b1, 4'd15, 1'b1, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);
    add(1'b1, 4'd15, 1'b0, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);
    add(1'b1, 4'd0,  1'b0, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);
    add(1'b1, 4'd0,  1'b1, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);
    add(1'b1, 4'd15, 1'b1, 1'b0, 1'b0,   8'd0, 8'd1, 8'd1);

    tick();
    tick();
    check("reset valid", 32'(d_valid), 32'd0);
    check("reset dir",   32'(d_dir),   32'd0);
    check("reset tally", 32'(d_tally), 32'd0);
    check("reset up",    32'(d_up),    32'd0);
    check("reset dn",    32'(d_dn),    32'd0);
    check("reset drop",  32'(d_drop),  32'd0);
`ifdef COUNT_WRAP_JUMP_CHK_EN
    check("reset jump",  32'(d_jump),  32'd0);
`endif
    rst = 1'b0;

    foreach (vq[i]) begin
      en     = vq[i].en;
      count  = vq[i].cnt;
      updown = vq[i].ud;
      tick();
      check($sformatf("v%0d valid", i), 32'(d_valid), 32'(vq[i].exp_valid));
      if (vq[i].exp_valid) begin
        check($sformatf("v%0d dir", i),   32'(d_dir),   32'(vq[i].exp_dir));
        check($sformatf("v%0d tally", i), 32'(d_tally), 32'(vq[i].exp_tally));
      end
      check($sformatf("v%0d up", i), 32'(d_up), 32'(vq[i].exp_up));
      check($sformatf("v%0d dn", i), 32'(d_dn), 32'(vq[i].exp_dn));
    end
    check("table drop", 32'(d_drop), 32'd0);

    // Backpressure: three up-wraps into a two-entry buffer, third one dropped.
    evt_ready = 1'b0;
    do_reset();
    prime15();
    up_wrap_full();
    check("A wrap1 valid", 32'(d_valid), 32'd1);
    up_wrap_full();
    up_wrap_full();
    rec = '{dir: d_dir, tally: d_tally};
    check("A head rec",  32'(rec),     32'({DIR_UP, 8'd1}));
    check("A valid",     32'(d_valid), 32'd1);
    check("A drop",      32'(d_drop),  32'd1);
    check("A up",        32'(d_up),    32'd3);
    en        = 1'b0;
    evt_ready = 1'b1;
    tick();
    check("A pop1 valid", 32'(d_valid), 32'd1);
    check("A pop1 tally", 32'(d_tally), 32'd2);
    tick();
    check("A pop2 valid", 32'(d_valid), 32'd0);
    check("A drop sticky", 32'(d_drop), 32'd1);

    // Push and pop in the same cycle while full: nothing is lost.
    evt_ready = 1'b0;
    do_reset();
    prime15();
    up_wrap_full();
    up_wrap_full();
    check("C full head", 32'(d_tally), 32'd1);
    ramp_to15();
    evt_ready = 1'b1;
    count     = 4'd0;
    tick();
    check("C valid",  32'(d_valid), 32'd1);
    check("C tally",  32'(d_tally), 32'd2);
    check("C drop",   32'(d_drop),  32'd0);
    check("C up",     32'(d_up),    32'd3);
    en = 1'b0;
    tick();
    check("C third tally", 32'(d_tally), 32'd3);
    check("C third valid", 32'(d_valid), 32'd1);
    tick();
    check("C empty", 32'(d_valid), 32'd0);

    // Saturation on the narrow-tally instance.
    evt_ready = 1'b1;
    do_reset();
    prime15();
    for (int k = 0; k < 5; k++) up_wrap_full();
    check("D sat valid", 32'(s_valid), 32'd1);
    check("D sat dir",   32'(s_dir),   32'(DIR_UP));
    check("D sat tally", 32'(s_tally), 32'd3);
    check("D sat up",    32'(s_up),    32'd3);
    check("D sat dn",    32'(s_dn),    32'd0);
    check("D wide up",   32'(d_up),    32'd5);
    check("D wide tally", 32'(d_tally), 32'd5);

    // Reset with an event buffered, then re-prime across a 15->0 step.
    evt_ready = 1'b0;
    do_reset();
    prime15();
    up_wrap_full();
    ramp_to15();
    check("E pre valid", 32'(d_valid), 32'd1);
    rst = 1'b1;
    tick();
    check("E rst valid", 32'(d_valid), 32'd0);
    check("E rst dir",   32'(d_dir),   32'd0);
    check("E rst tally", 32'(d_tally), 32'd0);
    check("E rst up",    32'(d_up),    32'd0);
    check("E rst drop",  32'(d_drop),  32'd0);
    rst       = 1'b0;
    evt_ready = 1'b1;
    count     = 4'd0;
    tick();
    check("E prime valid", 32'(d_valid), 32'd0);
    check("E prime up",    32'(d_up),    32'd0);
    for (int c = 1; c <= 3; c++) begin
      count = 4'(c);
      tick();
    end
    check("E step valid", 32'(d_valid), 32'd0);
`ifdef COUNT_WRAP_JUMP_CHK_EN
    check("E jump before", 32'(d_jump), 32'd0);
    count = 4'd7;
    tick();
    check("E jump after", 32'(d_jump),  32'd1);
    check("E jump no evt", 32'(d_valid), 32'd0);
`endif

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
